// File: rtl/fsm16bit_op_sequencer_pkg.sv
// rtl/fsm16bit_op_sequencer_pkg.sv - shared encodings and command word for the op sequencer
// Contents: op codes (OP_LOAD/OP_ARITH/OP_ROT/OP_NOP), FSM states (S_IDLE/S_ISSUE),
//           packed command word seq_cmd_t (CMD_W = 11 bits: op, dir, value, repeat).
package fsm16bit_op_sequencer_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ARITH = 2'b01;
    localparam logic [1:0] OP_ROT   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [1:0] op;
        logic       dir;
        logic [3:0] value;
        logic [3:0] rpt;     // issue count minus one
    } seq_cmd_t;

    localparam int CMD_W = $bits(seq_cmd_t);

    // NOP slots occupy time on the bus but never strobe the counter.
    function automatic logic op_updates_counter(input logic [1:0] op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// rtl/seq_cmd_fifo.sv - DEPTH-entry first-word-fall-through command FIFO
// Ports: clock, reset (async, active-low), push, wdata, pop, rdata (head entry), full, empty.
// Pushes when full and pops when empty are ignored; pointers wrap modulo DEPTH.
module seq_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop happens on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsm16bit_op_sequencer.sv
// rtl/fsm16bit_op_sequencer.sv - queues keypress op commands and drives the 16-bit counter's control inputs
// Ports: clock, reset (async, active-low); command in: cmd_valid/cmd_ready, cmd_op, cmd_dir, cmd_value,
//        cmd_repeat; hold; counter out: ctr_enable, ctr_check, ctr_mode, ctr_direction, ctr_value;
//        status: busy, done.
// Optional SEQ_OVF_FLAG_EN: adds ovf_clr input and sticky ovf output (set on a refused command).
module fsm16bit_op_sequencer
    import fsm16bit_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_dir,
    input  logic [3:0] cmd_value,
    input  logic [3:0] cmd_repeat,
    input  logic       hold,
    output logic       ctr_enable,
    output logic       ctr_check,
    output logic       ctr_mode,
    output logic       ctr_direction,
    output logic [3:0] ctr_value,
    output logic       busy,
    output logic       done
`ifdef SEQ_OVF_FLAG_EN
    ,
    input  logic       ovf_clr,
    output logic       ovf
`endif
);

    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;
    seq_cmd_t         head;

    seq_state_t       state_q, state_d;
    logic [3:0]       rep_q, rep_d;   // slots still to issue after the one on the bus
    logic             slot_q, slot_d; // a slot (possibly NOP) occupies the bus this cycle
    logic             last_d;
    logic             load;           // pop head and start it on the next cycle
    logic [1:0]       op_q, op_d;

    assign cmd_ready = ~fifo_full;
    assign head      = seq_cmd_t'(fifo_rdata);

    seq_cmd_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmd_valid),
        .wdata ({cmd_op, cmd_dir, cmd_value, cmd_repeat}),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy = (state_q == S_ISSUE) | ~fifo_empty;

    // Output registers describe the slot on the bus in the following cycle, so
    // every decision here is made one edge ahead. hold sampled at an edge
    // keeps the following cycle empty; a slot already on the bus still lands.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        slot_d  = 1'b0;
        last_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !hold) begin
                    load = 1'b1;
                end
            end
            S_ISSUE: begin
                if (slot_q && rep_q == 4'd0) begin
                    // Final slot of this command is on the bus: chain the next one
                    // without a bubble, or fall back to idle.
                    if (!fifo_empty && !hold) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!hold) begin
                    rep_d  = rep_q - 4'd1;
                    slot_d = 1'b1;
                    last_d = (rep_q == 4'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d = S_ISSUE;
            rep_d   = head.rpt;
            slot_d  = 1'b1;
            last_d  = (head.rpt == 4'd0);
        end
    end

    assign op_d = load ? head.op : op_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rep_q   <= 4'd0;
            slot_q  <= 1'b0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            slot_q  <= slot_d;
            op_q    <= op_d;
        end
    end

    // Control fields only change when a counter-updating command starts, so
    // they stay stable across the command and through idle/NOP periods.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctr_enable    <= 1'b0;
            ctr_check     <= 1'b0;
            ctr_mode      <= 1'b0;
            ctr_direction <= 1'b0;
            ctr_value     <= 4'd0;
            done          <= 1'b0;
        end else begin
            ctr_enable <= slot_d & op_updates_counter(op_d);
            done       <= last_d;
            if (load && op_updates_counter(head.op)) begin
                ctr_check     <= (head.op != OP_LOAD);
                ctr_mode      <= (head.op == OP_ROT);
                ctr_direction <= head.dir;
                ctr_value     <= head.value;
            end
        end
    end

`ifdef SEQ_OVF_FLAG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (cmd_valid && !cmd_ready) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fsm16bit_op_sequencer.sv
// tb/tb_fsm16bit_op_sequencer.sv - self-checking bench for fsm16bit_op_sequencer driving a 16-bit counter
module tb_fsm16bit_op_sequencer;

    localparam logic [1:0] T_LOAD  = 2'b00;
    localparam logic [1:0] T_ARITH = 2'b01;
    localparam logic [1:0] T_ROT   = 2'b10;
    localparam logic [1:0] T_NOP   = 2'b11;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [3:0] cmd_value;
    logic [3:0] cmd_repeat;
    logic       hold;
    logic       ctr_enable;
    logic       ctr_check;
    logic       ctr_mode;
    logic       ctr_direction;
    logic [3:0] ctr_value;
    logic       busy;
    logic       done;
`ifdef SEQ_OVF_FLAG_EN
    logic       ovf_clr;
    logic       ovf;
`endif

    fsm16bit_op_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_dir       (cmd_dir),
        .cmd_value     (cmd_value),
        .cmd_repeat    (cmd_repeat),
        .hold          (hold),
        .ctr_enable    (ctr_enable),
        .ctr_check     (ctr_check),
        .ctr_mode      (ctr_mode),
        .ctr_direction (ctr_direction),
        .ctr_value     (ctr_value),
        .busy          (busy),
        .done          (done)
`ifdef SEQ_OVF_FLAG_EN
        ,
        .ovf_clr       (ovf_clr),
        .ovf           (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Attached 16-bit counter: preset / add-sub / rotate by one.
    logic [15:0] cnt;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= 16'h0000;
        end else if (ctr_enable) begin
            if (!ctr_check)   cnt <= 16'h4732;
            else if (ctr_mode) cnt <= ctr_direction ? {cnt[0], cnt[15:1]} : {cnt[14:0], cnt[15]};
            else              cnt <= ctr_direction ? cnt - {12'h000, ctr_value} : cnt + {12'h000, ctr_value};
        end
    end

    // Reference: effect of a whole command on the count.
    function automatic logic [15:0] apply(input logic [15:0] c, input logic [1:0] op, input logic dir,
                                          input logic [3:0] val, input logic [3:0] rpt);
        for (int i = 0; i <= int'(rpt); i++) begin
            case (op)
                T_LOAD:  c = 16'h4732;
                T_ARITH: c = dir ? c - 16'(val) : c + 16'(val);
                T_ROT:   c = dir ? {c[0], c[15:1]} : {c[14:0], c[15]};
                default: c = c;
            endcase
        end
        return c;
    endfunction

    int          n_en;
    int          n_done;
    logic        hold_at_edge = 1'b0;
    logic        mon_on = 1'b0;
    logic [6:0]  exp_q[$];
    logic [6:0]  ev;
    logic [15:0] exp_cnt;
    int          exp_done;

    always @(posedge clock) hold_at_edge = hold;

    always @(negedge clock) begin
        if (ctr_enable) n_en++;
        if (done) n_done++;
        if (ctr_enable) chk("enable_after_hold", 32'(hold_at_edge), 0);
        if (mon_on) begin
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i <= int'(cmd_repeat); i++)
                    if (cmd_op != T_NOP)
                        exp_q.push_back({cmd_op != T_LOAD, cmd_op == T_ROT, cmd_dir, cmd_value});
                exp_cnt = apply(exp_cnt, cmd_op, cmd_dir, cmd_value, cmd_repeat);
                exp_done++;
            end
            if (ctr_enable) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_enable", 32'(ctr_enable), 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("rand_event_fields", 32'({ctr_check, ctr_mode, ctr_direction, ctr_value}), 32'(ev));
                end
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic dir, input logic [3:0] val, input logic [3:0] rpt);
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_value = val; cmd_repeat = rpt;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) @(negedge clock);
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        dir;
        logic [3:0]  val;
        logic [3:0]  rpt;
        logic [15:0] exp_cnt;
        int          exp_en;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int idx[$];
        logic [15:0] seen[$];

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
        cmd_value = 4'd0; cmd_repeat = 4'd0; hold = 1'b0;
`ifdef SEQ_OVF_FLAG_EN
        ovf_clr = 1'b0;
`endif
        vecs[0] = '{T_LOAD,  1'b0, 4'd0,  4'd0,  16'h4732, 1};
        vecs[1] = '{T_ARITH, 1'b0, 4'd5,  4'd2,  16'h4741, 3};
        vecs[2] = '{T_ROT,   1'b0, 4'd0,  4'd0,  16'h8E82, 1};
        vecs[3] = '{T_ROT,   1'b1, 4'd0,  4'd3,  16'h28E8, 4};
        vecs[4] = '{T_ARITH, 1'b1, 4'd9,  4'd1,  16'h28D6, 2};
        vecs[5] = '{T_NOP,   1'b0, 4'd0,  4'd5,  16'h28D6, 0};
        vecs[6] = '{T_ROT,   1'b0, 4'd0,  4'd15, 16'h28D6, 16};
        vecs[7] = '{T_ARITH, 1'b0, 4'd15, 4'd15, 16'h29C6, 16};
        vecs[8] = '{T_LOAD,  1'b0, 4'd0,  4'd3,  16'h4732, 4};
        vecs[9] = '{T_ARITH, 1'b1, 4'd15, 4'd0,  16'h4723, 1};

        // Reset state, during and after reset.
        @(negedge clock);
        chk("rst_outputs", 32'({ctr_enable, ctr_check, ctr_mode, ctr_direction, ctr_value, busy, done}), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
`ifdef SEQ_OVF_FLAG_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif

        // Latency of a single LOAD into an idle block.
        n_done = 0;
        push(T_LOAD, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        chk("lat_k_enable", 32'(ctr_enable), 0);
        chk("lat_k_busy", 32'(busy), 1);
        @(negedge clock);
        chk("lat_k1_enable", 32'(ctr_enable), 1);
        chk("lat_k1_check", 32'(ctr_check), 0);
        chk("lat_k1_done", 32'(done), 1);
        @(negedge clock);
        chk("lat_k2_enable", 32'(ctr_enable), 0);
        chk("lat_k2_count", 32'(cnt), 32'h4732);
        chk("lat_k2_busy", 32'(busy), 0);
        chk("lat_done_once", n_done, 1);

        // Table of single commands applied in sequence from reset.
        do_reset();
        for (int v = 0; v < 10; v++) begin
            n_en = 0; n_done = 0;
            push(vecs[v].op, vecs[v].dir, vecs[v].val, vecs[v].rpt);
            wait_idle(40);
            chk($sformatf("vec%0d_count", v), 32'(cnt), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_enables", v), n_en, vecs[v].exp_en);
            chk($sformatf("vec%0d_done", v), n_done, 1);
        end

        // Back-to-back commands issue on adjacent cycles.
        do_reset();
        push(T_ARITH, 1'b0, 4'd1, 4'd0);
        wait_idle(20);
        chk("b2b_start", 32'(cnt), 1);
        push(T_ROT, 1'b0, 4'd0, 4'd0);
        push(T_ARITH, 1'b1, 4'd1, 4'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ctr_enable) begin
                idx.push_back(c);
                seen.push_back(cnt);
            end
        end
        chk("b2b_enable_count", idx.size(), 2);
        if (idx.size() == 2) begin
            chk("b2b_adjacent", idx[1] - idx[0], 1);
            chk("b2b_mid_count", 32'(seen[1]), 2);
        end
        chk("b2b_final", 32'(cnt), 1);

        // Fill the FIFO under hold; a push offered on the pop edge is refused.
        do_reset();
        n_en = 0; n_done = 0;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push(T_NOP, 1'b0, 4'd0, 4'd15);
        chk("full_ready", 32'(cmd_ready), 0);
        chk("full_busy", 32'(busy), 1);
        cmd_valid = 1'b1; cmd_op = T_NOP; cmd_repeat = 4'd0;
        hold = 1'b0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk("after_pop_ready", 32'(cmd_ready), 1);
`ifdef SEQ_OVF_FLAG_EN
        chk("ovf_set", 32'(ovf), 1);
        @(negedge clock);
        chk("ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        @(posedge clock); #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);
`endif
        wait_idle(200);
        chk("full_dones", n_done, 4);
        chk("full_no_enable", n_en, 0);

        // Hold after three issues of an eight-issue add.
        do_reset();
        n_done = 0;
        push(T_ARITH, 1'b0, 4'd1, 4'd7);
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clock);
            if (ctr_enable) k++;
        end
        chk("hold_three_issued", k, 3);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("hold_c%0d_enable", c), 32'(ctr_enable), 0);
        end
        chk("hold_frozen_count", 32'(cnt), 3);
        hold = 1'b0;
        wait_idle(30);
        chk("hold_final_count", 32'(cnt), 8);
        chk("hold_done_once", n_done, 1);

        // Reset in the middle of a long command.
        do_reset();
        push(T_ARITH, 1'b0, 4'd1, 4'd15);
        push(T_LOAD, 1'b0, 4'd0, 4'd0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_enable", 32'(ctr_enable), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(cmd_ready), 1);
        chk("midrst_count", 32'(cnt), 0);
        @(negedge clock);
        reset = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ctr_enable) k++;
        end
        chk("midrst_no_enable", k, 0);
        chk("midrst_count_after", 32'(cnt), 0);

        // Randomized traffic against the scoreboard.
        do_reset();
        exp_cnt = 16'h0000; exp_done = 0; n_done = 0;
        exp_q.delete();
        mon_on = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(posedge clock); #1;
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_dir    = 1'($urandom_range(0, 1));
            cmd_value  = 4'($urandom_range(0, 15));
            cmd_repeat = 4'($urandom_range(0, 3));
            hold       = ($urandom_range(0, 4) == 0);
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0; hold = 1'b0;
        wait_idle(400);
        @(negedge clock);
        chk("rand_count", 32'(cnt), 32'(exp_cnt));
        chk("rand_dones", n_done, exp_done);
        chk("rand_events_left", exp_q.size(), 0);
        mon_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
